// File: rtl/demux1t16_32_buf.sv
// 1-to-16 word distributor: loads one of 16 single-entry channel buffers (or all of
// them in broadcast mode) and holds each word with a valid flag until acknowledged.
module demux1t16_32_buf #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              s,
    input  logic                    bcast,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_CH*WIDTH-1:0]   out_data,
    output logic [N_CH-1:0]         out_valid,
    input  logic [N_CH-1:0]         out_ack,
    output logic [4:0]              full_cnt
);

    logic [N_CH*WIDTH-1:0] data_q,  data_d;
    logic [N_CH-1:0]       valid_q, valid_d;
    logic [4:0]            cnt_q,   cnt_d;
    logic [N_CH-1:0]       free_s;
    logic [N_CH-1:0]       wr_en_s;

    function automatic logic [4:0] popcount16(input logic [N_CH-1:0] v);
        logic [4:0] acc;
        acc = 5'd0;
        for (int i = 0; i < N_CH; i++) begin
            acc = acc + {4'd0, v[i]};
        end
        return acc;
    endfunction

    // A channel can take a word if it is empty or being drained this same cycle.
    always_comb begin
        free_s = ~valid_q | out_ack;
        if (bcast) begin
            in_ready = &free_s;
        end else begin
            in_ready = free_s[s];
        end
    end

    // Decode which channels load in_data on this edge.
    always_comb begin
        wr_en_s = {N_CH{1'b0}};
        if (in_valid && in_ready) begin
            if (bcast) begin
                wr_en_s = {N_CH{1'b1}};
            end else begin
                wr_en_s = N_CH'(1) << s;
            end
        end else begin
            wr_en_s = {N_CH{1'b0}};
        end
    end

    // Next-state data/valid: a write overrides a same-cycle ack, keeping the channel full.
    always_comb begin
        data_d  = data_q;
        valid_d = (valid_q & ~out_ack) | wr_en_s;
        for (int k = 0; k < N_CH; k++) begin
            if (wr_en_s[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
            end else begin
                data_d[k*WIDTH +: WIDTH] = data_q[k*WIDTH +: WIDTH];
            end
        end
        cnt_d = popcount16(valid_d);
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {(N_CH*WIDTH){1'b0}};
            valid_q <= {N_CH{1'b0}};
            cnt_q   <= 5'd0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign full_cnt  = cnt_q;

endmodule

// File: tb/tb_demux1t16_32_buf.sv
// Self-checking bench for demux1t16_32_buf: directed scenarios plus randomized traffic
// compared against an array-based channel model.
module tb_demux1t16_32_buf;

    logic         clk;
    logic         rst_n;
    logic [3:0]   s;
    logic         bcast;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] out_data;
    logic [15:0]  out_valid;
    logic [15:0]  out_ack;
    logic [4:0]   full_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_data  [16];
    bit          m_valid [16];

    demux1t16_32_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .bcast    (bcast),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .full_cnt (full_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        bit all_free = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (m_valid[k] && !out_ack[k]) all_free = 1'b0;
        end
        if (bcast) return all_free;
        return !m_valid[s] || out_ack[s];
    endfunction

    function automatic logic [511:0] m_flat();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = m_data[k];
        return f;
    endfunction

    function automatic logic [15:0] m_vflat();
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int k = 0; k < 16; k++) c += m_valid[k] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 16; k++) begin
            m_data[k]  = 32'd0;
            m_valid[k] = 1'b0;
        end
    endtask

    // One clock edge: the model applies acks first, then the accepted write.
    task automatic tick();
        bit acc;
        acc = in_valid && m_ready();
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            if (out_ack[k]) m_valid[k] = 1'b0;
            if (acc && (bcast || k == int'(s))) begin
                m_data[k]  = in_data;
                m_valid[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic b,
                         input logic [31:0] d, input logic [15:0] ack);
        @(negedge clk);
        in_valid = v; s = sel; bcast = b; in_data = d; out_ack = ack;
        #1;
    endtask

    task automatic drain_all();
        drive(1'b0, 4'd0, 1'b0, 32'd0, 16'hFFFF);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; s = 4'd0; bcast = 1'b0; in_data = 32'd0; out_ack = 16'd0;
        m_clear();
        #12;
        n_cmp++; if (out_valid !== 16'd0) begin n_bad++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
        n_cmp++; if (out_data !== 512'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_cmp++; if (full_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", full_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        drive(1'b1, 4'h5, 1'b0, 32'hDEADBEEF, 16'd0);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 16'h0020) begin n_bad++; $display("FAIL single_valid got=%h exp=0020", out_valid); end
        n_cmp++; if (out_data[191:160] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_lane5 got=%h exp=deadbeef", out_data[191:160]); end
        n_cmp++; if (out_data !== m_flat()) begin n_bad++; $display("FAIL single_data got=%h exp=%h", out_data, m_flat()); end
        n_cmp++; if (full_cnt !== 5'd1) begin n_bad++; $display("FAIL single_cnt got=%0d exp=1", full_cnt); end
    endtask

    task automatic test_full_then_ack();
        drive(1'b1, 4'h5, 1'b0, 32'h1, 16'd0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        tick();
        n_cmp++; if (out_data[191:160] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_hold got=%h exp=deadbeef", out_data[191:160]); end
        drive(1'b1, 4'h5, 1'b0, 32'h1, 16'h0020);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ackwr_ready got=%b exp=1", in_ready); end
        tick();
        n_cmp++; if (out_data[191:160] !== 32'h1) begin n_bad++; $display("FAIL ackwr_lane5 got=%h exp=1", out_data[191:160]); end
        n_cmp++; if (out_valid !== 16'h0020) begin n_bad++; $display("FAIL ackwr_valid got=%h exp=0020", out_valid); end
        n_cmp++; if (full_cnt !== 5'd1) begin n_bad++; $display("FAIL ackwr_cnt got=%0d exp=1", full_cnt); end
    endtask

    task automatic test_fill_all();
        drain_all();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'(k), 1'b0, 32'h100 + 32'(k), 16'd0);
            tick();
        end
        n_cmp++; if (out_valid !== 16'hFFFF) begin n_bad++; $display("FAIL fill_valid got=%h exp=ffff", out_valid); end
        n_cmp++; if (full_cnt !== 5'd16) begin n_bad++; $display("FAIL fill_cnt got=%0d exp=16", full_cnt); end
        drain_all();
        n_cmp++; if (out_valid !== 16'h0000) begin n_bad++; $display("FAIL drain_valid got=%h exp=0", out_valid); end
        n_cmp++; if (full_cnt !== 5'd0) begin n_bad++; $display("FAIL drain_cnt got=%0d exp=0", full_cnt); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (out_data[k*32 +: 32] !== 32'h100 + 32'(k)) begin
                n_bad++; $display("FAIL drain_lane%0d got=%h exp=%h", k, out_data[k*32 +: 32], 32'h100 + 32'(k));
            end
        end
    endtask

    task automatic test_bcast();
        logic [31:0] d;
        d = $urandom;
        drive(1'b1, 4'h3, 1'b0, 32'hCAFE0003, 16'd0);
        tick();
        drive(1'b1, 4'h0, 1'b1, d, 16'd0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bcast_blocked got=%b exp=0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 16'h0008) begin n_bad++; $display("FAIL bcast_hold got=%h exp=0008", out_valid); end
        drive(1'b1, 4'h0, 1'b1, d, 16'h0008);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bcast_ready got=%b exp=1", in_ready); end
        tick();
        n_cmp++; if (out_data !== {16{d}}) begin n_bad++; $display("FAIL bcast_data got=%h exp=%h", out_data, {16{d}}); end
        n_cmp++; if (full_cnt !== 5'd16) begin n_bad++; $display("FAIL bcast_cnt got=%0d exp=16", full_cnt); end
    endtask

    task automatic test_empty_ack_concurrent();
        drain_all();
        drive(1'b0, 4'h0, 1'b0, 32'd0, 16'hFFFF);
        tick();
        n_cmp++; if (full_cnt !== 5'd0) begin n_bad++; $display("FAIL emptyack_cnt got=%0d exp=0", full_cnt); end
        n_cmp++; if (out_data !== m_flat()) begin n_bad++; $display("FAIL emptyack_data got=%h exp=%h", out_data, m_flat()); end
        drive(1'b1, 4'h2, 1'b0, 32'h22222222, 16'd0);
        tick();
        drive(1'b1, 4'h9, 1'b0, 32'h99999999, 16'h0004);
        tick();
        n_cmp++; if (out_valid !== 16'h0200) begin n_bad++; $display("FAIL concur_valid got=%h exp=0200", out_valid); end
        n_cmp++; if (out_data[319:288] !== 32'h99999999) begin n_bad++; $display("FAIL concur_lane9 got=%h exp=99999999", out_data[319:288]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), $urandom,
                  16'($urandom) & 16'($urandom));
            n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, m_ready()); end
            tick();
            n_cmp++; if (out_valid !== m_vflat()) begin n_bad++; $display("FAIL rand_valid i=%0d got=%h exp=%h", i, out_valid, m_vflat()); end
            n_cmp++; if (out_data !== m_flat()) begin n_bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, out_data, m_flat()); end
            n_cmp++; if (int'(full_cnt) != m_cnt()) begin n_bad++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, full_cnt, m_cnt()); end
        end
    endtask

    task automatic test_async_reset();
        drain_all();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 4'(k), 1'b0, $urandom, 16'd0);
            tick();
        end
        drive(1'b0, 4'd0, 1'b0, 32'd0, 16'd0);
        n_cmp++; if (full_cnt !== 5'd7) begin n_bad++; $display("FAIL prerst_cnt got=%0d exp=7", full_cnt); end
        #1;
        rst_n = 1'b0;
        m_clear();
        #1;
        n_cmp++; if (out_valid !== 16'd0) begin n_bad++; $display("FAIL arst_valid got=%h exp=0", out_valid); end
        n_cmp++; if (out_data !== 512'd0) begin n_bad++; $display("FAIL arst_data got=%h exp=0", out_data); end
        n_cmp++; if (full_cnt !== 5'd0) begin n_bad++; $display("FAIL arst_cnt got=%0d exp=0", full_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'hA, 1'b0, 32'h0A0A0A0A, 16'd0);
        tick();
        n_cmp++; if (out_valid !== 16'h0400) begin n_bad++; $display("FAIL postrst_valid got=%h exp=0400", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_then_ack();
        test_fill_all();
        test_bcast();
        test_empty_ack_concurrent();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
